lc3_mem_unit: RTL and testbench

//  MAR/MDR register pair plus memory-bus sequencer for the LC-3 datapath.

---
 rtl/lc3_pkg.sv | 14 +
 rtl/lc3_timeout_ctr.sv | 31 +++
 rtl/lc3_mem_unit.sv | 114 +++++++++++
 tb/tb_lc3_mem_unit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_pkg.sv
// Shared types and widths for the LC-3 memory unit.
package lc3_pkg;

    localparam int LC3_AW = 16;
    localparam int LC3_DW = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2,
        ERR     = 2'd3
    } mem_state_t;

endpackage

// File: rtl/lc3_timeout_ctr.sv
// Saturating wait-cycle counter; o_expire marks the last allowed wait cycle.
module lc3_timeout_ctr #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int             CW   = $clog2(TIMEOUT);
    localparam logic [CW-1:0]  LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != LAST)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expire = (r_count == LAST);

endmodule

// File: rtl/lc3_mem_unit.sv
// MAR/MDR register pair and req/ack memory sequencer for the LC-3 datapath.
module lc3_mem_unit
    import lc3_pkg::*;
#(
    parameter int              AW       = LC3_AW,
    parameter int              DW       = LC3_DW,
    parameter int              TIMEOUT  = 64,
    parameter logic [DW-1:0]   ERR_DATA = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] bus_in,
    input  logic          ldMAR,
    input  logic          ldMDR,
    input  logic          selMDR,
    input  logic          memWE,
    output logic [DW-1:0] mdr_out,
    output logic          stall,
    output logic          bus_err,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_req,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack
);

    mem_state_t    r_state;
    logic [AW-1:0] r_mar;
    logic [DW-1:0] r_mdr;
    logic          r_bus_err;
    logic          r_mem_req;
    logic          r_mem_we;

    logic          w_waiting;
    logic          w_expire;

    assign w_waiting = (r_state == RD_WAIT) || (r_state == WR_WAIT);

    lc3_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (r_state == IDLE),
        .i_enable (w_waiting && !mem_ack),
        .o_expire (w_expire)
    );

    // Bus loads are accepted only in IDLE so MAR/MDR stay stable for memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_mar     <= '0;
            r_mdr     <= '0;
            r_bus_err <= 1'b0;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (ldMAR)
                        r_mar <= AW'(bus_in);
                    if (ldMDR && !selMDR)
                        r_mdr <= bus_in;
                    if (memWE) begin
                        r_state   <= WR_WAIT;
                        r_mem_req <= 1'b1;
                        r_mem_we  <= 1'b1;
                    end else if (ldMDR && selMDR) begin
                        r_state   <= RD_WAIT;
                        r_mem_req <= 1'b1;
                        r_mem_we  <= 1'b0;
                    end
                end
                RD_WAIT: begin
                    if (mem_ack) begin
                        r_mdr     <= mem_rdata;
                        r_mem_req <= 1'b0;
                        r_state   <= IDLE;
                    end else if (w_expire) begin
                        r_state <= ERR;
                    end
                end
                WR_WAIT: begin
                    if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_state   <= IDLE;
                    end else if (w_expire) begin
                        r_state <= ERR;
                    end
                end
                ERR: begin
                    // mem_we still tells which kind of transaction was aborted.
                    r_mem_req <= 1'b0;
                    r_bus_err <= 1'b1;
                    if (!r_mem_we)
                        r_mdr <= ERR_DATA;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign stall     = (r_state != IDLE);
    assign mdr_out   = r_mdr;
    assign bus_err   = r_bus_err;
    assign mem_addr  = r_mar;
    assign mem_wdata = r_mdr;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;

endmodule

// File: tb/tb_lc3_mem_unit.sv
// Directed bench for lc3_mem_unit: fetch, write, timeout, busy-ignore, conflict, reset.
module tb_lc3_mem_unit;

    localparam int TIMEOUT = 64;

    logic        clk;
    logic        rst_n;
    logic [15:0] bus_in;
    logic        ldMAR;
    logic        ldMDR;
    logic        selMDR;
    logic        memWE;
    logic [15:0] mdr_out;
    logic        stall;
    logic        bus_err;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_rdata;
    logic        mem_ack;

    int n_checks;
    int n_fail;
    int stall_cycles;
    int wr_req_cycles;

    lc3_mem_unit #(
        .AW       (16),
        .DW       (16),
        .TIMEOUT  (TIMEOUT),
        .ERR_DATA (16'h0000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus_in    (bus_in),
        .ldMAR     (ldMAR),
        .ldMDR     (ldMDR),
        .selMDR    (selMDR),
        .memWE     (memWE),
        .mdr_out   (mdr_out),
        .stall     (stall),
        .bus_err   (bus_err),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs changed afterwards are sampled at the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctl();
        ldMAR  = 1'b0;
        ldMDR  = 1'b0;
        selMDR = 1'b0;
        memWE  = 1'b0;
    endtask

    // Called in the first cycle with stall high; acks in stall cycle ack_at (0 = never).
    task automatic run_wait(input int ack_at, input logic [15:0] rdata,
                            output int n_stall, output int n_wr_req);
        n_stall  = 0;
        n_wr_req = 0;
        for (int i = 0; i < 200 && stall; i++) begin
            n_stall++;
            if (mem_req && mem_we)
                n_wr_req++;
            if (n_stall == ack_at) begin
                mem_ack   = 1'b1;
                mem_rdata = rdata;
            end
            tick();
            mem_ack = 1'b0;
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        bus_in    = '0;
        mem_rdata = '0;
        mem_ack   = 1'b0;
        clear_ctl();

        // Reset state
        #12;
        check("rst_req",   32'(mem_req),  32'h0);
        check("rst_we",    32'(mem_we),   32'h0);
        check("rst_stall", 32'(stall),    32'h0);
        check("rst_mdr",   32'(mdr_out),  32'h0);
        check("rst_mar",   32'(mem_addr), 32'h0);
        check("rst_err",   32'(bus_err),  32'h0);
        rst_n = 1'b1;
        tick();

        // 1. Fetch read with ack in the fourth wait cycle
        bus_in = 16'h3000; ldMAR = 1'b1;
        tick();
        clear_ctl();
        check("t1_mar",      32'(mem_addr), 32'h3000);
        check("t1_idle",     32'(stall),    32'h0);
        ldMDR = 1'b1; selMDR = 1'b1;
        tick();
        clear_ctl();
        check("t1_req",      32'(mem_req),  32'h1);
        check("t1_rd",       32'(mem_we),   32'h0);
        run_wait(4, 16'h1234, stall_cycles, wr_req_cycles);
        check("t1_stall",    32'(stall_cycles), 32'd4);
        check("t1_mdr",      32'(mdr_out),  32'h1234);
        check("t1_req_drop", 32'(mem_req),  32'h0);

        // 2. Write acked in the first wait cycle
        bus_in = 16'h4000; ldMAR = 1'b1;
        tick();
        clear_ctl();
        bus_in = 16'hBEEF; ldMDR = 1'b1; selMDR = 1'b0;
        tick();
        clear_ctl();
        check("t2_mdr_bus",  32'(mdr_out),   32'hBEEF);
        check("t2_no_stall", 32'(stall),     32'h0);
        check("t2_no_req",   32'(mem_req),   32'h0);
        memWE = 1'b1;
        tick();
        clear_ctl();
        check("t2_we",       32'(mem_we),    32'h1);
        check("t2_addr",     32'(mem_addr),  32'h4000);
        check("t2_wdata",    32'(mem_wdata), 32'hBEEF);
        run_wait(1, 16'h0000, stall_cycles, wr_req_cycles);
        check("t2_stall",    32'(stall_cycles),  32'd1);
        check("t2_wr_req",   32'(wr_req_cycles), 32'd1);
        check("t2_req_drop", 32'(mem_req),   32'h0);

        // 3. Read timeout, then a good read with bus_err sticky
        ldMDR = 1'b1; selMDR = 1'b1;
        tick();
        clear_ctl();
        run_wait(0, 16'h0000, stall_cycles, wr_req_cycles);
        check("t3_stall",    32'(stall_cycles), 32'(TIMEOUT + 1));
        check("t3_err",      32'(bus_err),  32'h1);
        check("t3_mdr",      32'(mdr_out),  32'h0000);
        check("t3_req_drop", 32'(mem_req),  32'h0);
        ldMDR = 1'b1; selMDR = 1'b1;
        tick();
        clear_ctl();
        run_wait(2, 16'hA5A5, stall_cycles, wr_req_cycles);
        check("t3_stall2",   32'(stall_cycles), 32'd2);
        check("t3_mdr2",     32'(mdr_out),  32'hA5A5);
        check("t3_sticky",   32'(bus_err),  32'h1);

        // 4. Bus loads ignored while a read is in flight
        ldMDR = 1'b1; selMDR = 1'b1;
        tick();
        bus_in = 16'hFFFF; ldMAR = 1'b1; ldMDR = 1'b1; selMDR = 1'b0;
        tick();
        clear_ctl();
        check("t4_mar_hold", 32'(mem_addr), 32'h4000);
        check("t4_mdr_hold", 32'(mdr_out),  32'hA5A5);
        run_wait(2, 16'h5A5A, stall_cycles, wr_req_cycles);
        check("t4_stall",    32'(stall_cycles), 32'd2);
        check("t4_mdr",      32'(mdr_out),  32'h5A5A);
        check("t4_mar",      32'(mem_addr), 32'h4000);

        // 5. Write beats read in the same cycle; new MAR used
        bus_in = 16'h5000; ldMAR = 1'b1; memWE = 1'b1; ldMDR = 1'b1; selMDR = 1'b1;
        tick();
        clear_ctl();
        check("t5_we",       32'(mem_we),    32'h1);
        check("t5_req",      32'(mem_req),   32'h1);
        check("t5_addr",     32'(mem_addr),  32'h5000);
        check("t5_wdata",    32'(mem_wdata), 32'h5A5A);
        run_wait(1, 16'h1111, stall_cycles, wr_req_cycles);
        check("t5_stall",    32'(stall_cycles), 32'd1);
        check("t5_mdr",      32'(mdr_out),   32'h5A5A);

        // 6. Asynchronous reset mid-read; late ack ignored
        ldMDR = 1'b1; selMDR = 1'b1;
        tick();
        clear_ctl();
        tick();
        check("t6_in_read",  32'(stall),    32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_req",      32'(mem_req),  32'h0);
        check("t6_stall",    32'(stall),    32'h0);
        check("t6_mar",      32'(mem_addr), 32'h0);
        check("t6_mdr",      32'(mdr_out),  32'h0);
        check("t6_err",      32'(bus_err),  32'h0);
        tick();
        rst_n     = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 16'hDEAD;
        tick();
        mem_ack = 1'b0;
        tick();
        check("t6_late_stall", 32'(stall),   32'h0);
        check("t6_late_mdr",   32'(mdr_out), 32'h0);
        check("t6_late_req",   32'(mem_req), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
